// File: rtl/lottery_arbiter_pkg.sv
// ahb_arb_pkg: shared constants, FSM encoding and one-hot decode for the lottery arbiter
package ahb_arb_pkg;
   localparam int NUM_MASTERS = 4;
   localparam int MIDX_W = 2;
   localparam int TICKET_W = 4;
   typedef enum logic {PARK, OWN} state_e;
   function automatic logic [MIDX_W-1:0] oh2idx(input logic [NUM_MASTERS-1:0] oh);
      oh2idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) if (oh[i]) oh2idx = MIDX_W'(i);
   endfunction
endpackage

// File: rtl/lottery_arbiter_if.sv
// lottery_arbiter_if: AHB request/ticket/grant bundle between bus masters and the arbiter
interface lottery_arbiter_if #(parameter int TICKET_W = ahb_arb_pkg::TICKET_W);
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic hready;
   logic [TICKET_W-1:0] t0, t1, t2, t3;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic hmastlock;
   modport master (output hbusreq, hlock, hready, t0, t1, t2, t3, input hgrant, hmaster, hmastlock);
   modport slave (input hbusreq, hlock, hready, t0, t1, t2, t3, output hgrant, hmaster, hmastlock);
endinterface

// File: rtl/lottery_arbiter_pick.sv
// lottery_pick: highest ticket among requesters; ties go to the first found scanning from rr_ptr
module lottery_pick #(parameter int TICKET_W = 4) (
   input  logic [3:0]          i_req,
   input  logic [TICKET_W-1:0] i_t0,
   input  logic [TICKET_W-1:0] i_t1,
   input  logic [TICKET_W-1:0] i_t2,
   input  logic [TICKET_W-1:0] i_t3,
   input  logic [1:0]          i_rr_ptr,
   output logic [1:0]          o_winner,
   output logic                o_valid
);
   logic [TICKET_W-1:0] w_t [4];
   logic [TICKET_W-1:0] w_best;
   logic [1:0] w_idx;
   assign w_t = '{i_t0, i_t1, i_t2, i_t3};
   // strict > keeps the earliest tied master in scan order
   always_comb begin
      o_winner = '0;
      o_valid = 1'b0;
      w_best = '0;
      w_idx = '0;
      for (int k = 0; k < 4; k++) begin
         w_idx = i_rr_ptr + 2'(k);
         if (i_req[w_idx] && (!o_valid || w_t[w_idx] > w_best)) begin
            o_valid = 1'b1;
            o_winner = w_idx;
            w_best = w_t[w_idx];
         end
      end
   end
endmodule

// File: rtl/lottery_arbiter.sv
// lottery_arbiter: 4-master AHB arbiter driven by lottery tickets, with locking and a bus-hold limit
module lottery_arbiter #(
   parameter int TICKET_W = 4,
   parameter int MAX_HOLD = 16,
   parameter int DEFAULT_MASTER = 0
) (
   input logic clk,
   input logic reset,
   lottery_arbiter_if.slave bus
);
   import ahb_arb_pkg::*;
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
   localparam logic [1:0] DM = 2'(DEFAULT_MASTER);
   state_e r_state, w_state;
   logic [3:0] r_grant, w_grant, w_req;
   logic [1:0] r_master, r_rr, w_rr, w_owner, w_winner;
   logic [7:0] r_hold, w_hold;
   logic r_mastlock, w_valid, w_others, w_keep;
   assign w_owner = oh2idx(r_grant);
   assign w_others = |(bus.hbusreq & ~r_grant);
   assign w_keep = (r_state == OWN) && (bus.hlock[w_owner] ||
                   (bus.hbusreq[w_owner] && (!w_others || r_hold < HOLD_LIM)));
   // a releasing or expired owner never re-wins against itself
   assign w_req = (r_state == OWN) ? bus.hbusreq & ~r_grant : bus.hbusreq;
   lottery_pick #(.TICKET_W(TICKET_W)) u_pick (
      .i_req(w_req),
      .i_t0(bus.t0),
      .i_t1(bus.t1),
      .i_t2(bus.t2),
      .i_t3(bus.t3),
      .i_rr_ptr(r_rr),
      .o_winner(w_winner),
      .o_valid(w_valid)
   );
   always_comb begin
      w_state = r_state;
      w_grant = r_grant;
      w_rr = r_rr;
      w_hold = r_hold;
      if (w_keep) begin
         w_hold = (w_others && r_hold < HOLD_LIM) ? r_hold + 8'd1 : r_hold;
      end else if (w_valid) begin
         w_state = OWN;
         w_grant = 4'b1 << w_winner;
         w_rr = w_winner + 2'd1;
         w_hold = '0;
      end else begin
         w_state = PARK;
         w_grant = 4'b1 << DM;
         w_hold = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= PARK;
         r_grant <= 4'b1 << DM;
         r_master <= DM;
         r_mastlock <= 1'b0;
         r_rr <= '0;
         r_hold <= '0;
      end else if (bus.hready) begin
         r_state <= w_state;
         r_grant <= w_grant;
         r_rr <= w_rr;
         r_hold <= w_hold;
         r_master <= w_owner;
         r_mastlock <= bus.hlock[w_owner];
      end
   end
   assign bus.hgrant = r_grant;
   assign bus.hmaster = r_master;
   assign bus.hmastlock = r_mastlock;
endmodule

// File: tb/tb_lottery_arbiter.sv
// tb_lottery_arbiter: scoreboard bench with a cycle model plus directed lottery/lock/stall/reset checks
module tb_lottery_arbiter;
   import ahb_arb_pkg::*;
   localparam int MAXH = 16;
   localparam int DMST = 0;
   typedef struct {
      logic [3:0] g;
      logic [1:0] m;
      logic l;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] busreq = '0;
   logic [3:0] lock = '0;
   logic rdy = 1'b1;
   logic [3:0] tk [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
   int n_chk = 0;
   int n_err = 0;
   int m_state, m_grant, m_rr, m_hold, m_master, m_lock;
   exp_t sb[$];
   lottery_arbiter_if #(.TICKET_W(4)) bus();
   assign bus.hbusreq = busreq;
   assign bus.hlock = lock;
   assign bus.hready = rdy;
   assign bus.t0 = tk[0];
   assign bus.t1 = tk[1];
   assign bus.t2 = tk[2];
   assign bus.t3 = tk[3];
   lottery_arbiter #(.TICKET_W(4), .MAX_HOLD(MAXH), .DEFAULT_MASTER(DMST)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // key = ticket, then closeness to rr pointer; the largest key wins
   function automatic int m_pick(input logic [3:0] req, input int rr);
      int best = -1;
      int w = -1;
      for (int i = 0; i < 4; i++)
         if (req[i] && (int'(tk[i]) * 4 + 3 - ((i - rr + 4) % 4)) > best) begin
            best = int'(tk[i]) * 4 + 3 - ((i - rr + 4) % 4);
            w = i;
         end
      return w;
   endfunction
   task automatic model_step();
      int w, nm, nl;
      logic [3:0] oth;
      if (reset) begin
         m_state = 0; m_grant = DMST; m_rr = 0; m_hold = 0; m_master = DMST; m_lock = 0;
      end else if (rdy) begin
         nm = m_grant;
         nl = int'(lock[m_grant]);
         oth = busreq & ~(4'b1 << m_grant);
         if (m_state == 1 && (lock[m_grant] || (busreq[m_grant] && (oth == 0 || m_hold < MAXH - 1)))) begin
            if (oth != 0 && m_hold < MAXH - 1) m_hold++;
         end else begin
            w = m_pick(m_state == 1 ? oth : busreq, m_rr);
            m_hold = 0;
            if (w >= 0) begin
               m_state = 1; m_grant = w; m_rr = (w + 1) % 4;
            end else begin
               m_state = 0; m_grant = DMST;
            end
         end
         m_master = nm;
         m_lock = nl;
      end
   endtask
   task automatic cyc();
      exp_t e;
      model_step();
      e.g = 4'b1 << m_grant;
      e.m = 2'(m_master);
      e.l = m_lock[0];
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_hgrant", bus.hgrant, e.g);
      chk("sb_hmaster", bus.hmaster, e.m);
      chk("sb_hmastlock", bus.hmastlock, e.l);
   endtask
   initial begin
      int n;
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      chk("rst_hgrant", bus.hgrant, 4'b0001);
      chk("rst_hmaster", bus.hmaster, 2'd0);
      chk("rst_hmastlock", bus.hmastlock, 1'b0);
      chk("rst_state", dut.r_state, PARK);
      repeat (5) cyc();
      chk("park_hgrant", bus.hgrant, 4'b0001);
      busreq = 4'b1010; tk[1] = 4'd3; tk[3] = 4'd9;
      cyc();
      chk("lot_hgrant", bus.hgrant, 4'b1000);
      cyc();
      chk("lot_hmaster", bus.hmaster, 2'd3);
      busreq = '0;
      cyc(); cyc();
      busreq = 4'b0010;
      cyc();
      busreq = '0;
      cyc();
      chk("rr_after_m1", dut.r_rr, 2'd2);
      busreq = 4'b0110; tk[1] = 4'd5; tk[2] = 4'd5;
      cyc();
      chk("tie_hgrant", bus.hgrant, 4'b0100);
      chk("tie_rr", dut.r_rr, 2'd3);
      busreq = 4'b0010;
      cyc();
      chk("tie2_hgrant", bus.hgrant, 4'b0010);
      busreq = '0;
      cyc(); cyc();
      busreq = 4'b0001;
      cyc();
      chk("m0_hgrant", bus.hgrant, 4'b0001);
      busreq = 4'b0011;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         n++;
         if (bus.hgrant != 4'b0001) break;
      end
      chk("hold_limit_cycles", n, 16);
      chk("hold_limit_hgrant", bus.hgrant, 4'b0010);
      busreq = '0;
      cyc(); cyc();
      busreq = 4'b0001;
      cyc();
      lock = 4'b0001; busreq = 4'b0011;
      n = 0;
      for (int i = 0; i < 45; i++) begin
         cyc();
         if (bus.hgrant == 4'b0001) n++;
      end
      chk("lock_keep_cycles", n, 45);
      chk("lock_hmastlock", bus.hmastlock, 1'b1);
      lock = '0; busreq = '0;
      cyc(); cyc();
      busreq = 4'b0100;
      cyc();
      busreq = 4'b0110;
      cyc(); cyc();
      rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         busreq = 4'($urandom);
         cyc();
      end
      chk("stall_hgrant", bus.hgrant, 4'b0100);
      chk("stall_hmaster", bus.hmaster, 2'd2);
      chk("stall_hold", dut.r_hold, 8'd2);
      rdy = 1'b1; busreq = 4'b0010;
      cyc();
      chk("resume_hgrant", bus.hgrant, 4'b0010);
      busreq = '0;
      cyc(); cyc();
      busreq = 4'b1000; lock = 4'b1000;
      cyc(); cyc();
      chk("m3_lock_hmastlock", bus.hmastlock, 1'b1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("abort_hgrant", bus.hgrant, 4'b0001);
      chk("abort_hmastlock", bus.hmastlock, 1'b0);
      chk("abort_state", dut.r_state, PARK);
      for (int i = 0; i < 400; i++) begin
         busreq = 4'($urandom);
         lock = 4'($urandom) & 4'($urandom) & 4'($urandom);
         for (int j = 0; j < 4; j++) tk[j] = 4'($urandom_range(0, 15));
         rdy = $urandom_range(0, 4) != 0;
         reset = $urandom_range(0, 60) == 0;
         cyc();
      end
      reset = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/lottery_arbiter.md
Name: lottery_arbiter

Overview:
- AHB bus arbiter for 4 masters that consumes the four 4-bit lottery tickets produced by the ticket generator; tickets change on negedge clk and are sampled here on posedge.
- Among requesting masters, the highest ticket wins; ties break round-robin.
- Drives hgrant/hmaster/hmastlock to the AHB address/data-phase logic; supports locked transfers and a bounded bus-hold limit.

Parameters:
- TICKET_W, 4, ticket width in bits.
- MAX_HOLD, 16, max consecutive hready cycles an unlocked owner keeps the bus while others request (range 2..255).
- DEFAULT_MASTER, 0, master parked on the bus when nobody requests (0..3).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- hbusreq  input  4  per-master bus request.
- hlock  input  4  per-master lock request.
- hready  input  1  AHB transfer-done; arbitration and hmaster update only when 1.
- t0, t1, t2, t3  input  TICKET_W each  lottery tickets for masters 0..3.
- hgrant  output  4  one-hot grant.
- hmaster  output  2  index of the master owning the address phase.
- hmastlock  output  1  current transfer is locked.

Behaviour:
- Reset (sync, active-high), values at the next posedge:
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = DEFAULT_MASTER; hmastlock = 0.
  - state = PARK; rr_ptr = 0; hold_cnt = 0.
  - Reset asserted mid-ownership aborts the ownership immediately.
- States:
  - PARK: no request; grant held by DEFAULT_MASTER.
  - OWN: a requester holds the grant.
- Winner selection (combinational, over masters with hbusreq=1):
  - Maximum ticket value wins. A ticket of 0 still wins if its master is the sole requester.
  - Ties: first tied master found scanning cyclically from rr_ptr.
- Evaluated only on a posedge with hready=1. With hready=0, every register holds: hgrant, hmaster, hmastlock, hold_cnt, state, rr_ptr.
- PARK -> OWN when any hbusreq=1: hgrant = one-hot(winner); rr_ptr = winner+1 mod 4; hold_cnt = 0.
- OWN, owner keeps the bus when:
  - hlock[owner]=1, regardless of hold_cnt or other requests; or
  - hbusreq[owner]=1 and (no other requester or hold_cnt < MAX_HOLD-1).
  - While keeping: hold_cnt increments only if another master requests; it saturates at MAX_HOLD-1 and clears on each grant change.
- OWN, re-arbitration when the owner releases (hbusreq=0 and hlock=0) or hits the hold limit:
  - Winner picked from the current requesters. The owner may re-win only if it is still requesting and no one else is.
  - No requesters -> PARK, grant to DEFAULT_MASTER.
- hmaster/hmastlock have a one-cycle lag behind the grant: on each posedge with hready=1, hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)], both using pre-edge values.
- Simultaneous events: grant change and hmaster update on the same edge are legal (pipeline). A lock raised on the same edge as hold-limit expiry keeps the bus.
- hgrant is always exactly one-hot; never all zero.

Decomposition:
- Package ahb_arb_pkg:
  - NUM_MASTERS=4, MIDX_W=2, TICKET_W default.
  - State encoding PARK/OWN.
  - onehot-to-index function.
- One combinational sub-module, lottery_pick. Inputs: req[3:0], four tickets, rr_ptr. Outputs: winner[1:0], valid.
- lottery_arbiter instantiates lottery_pick and holds the registers and FSM.

Test Plan:
- Reset with hbusreq=0 -> hgrant=4'b0001, hmaster=0, hmastlock=0; these persist for 5 cycles in PARK.
- hbusreq=4'b1010, t1=3, t3=9, hready=1 -> hgrant=4'b1000 after 1 edge; hmaster=3 one edge later.
- hbusreq=4'b0110, t1=t2=5, rr_ptr=2 -> master 2 granted and rr_ptr becomes 3. Repeat with equal tickets after master 2 releases -> master 1 granted.
- Master 0 owns with hbusreq=4'b0011, hlock=0, MAX_HOLD=16 -> grant moves to master 1 after exactly 16 hready cycles. Same stimulus with hlock[0]=1 -> master 0 keeps the bus for 40+ cycles and hmastlock=1.
- Owner 2 with hready held 0 for 6 cycles while hbusreq changes -> hgrant, hmaster and hold_cnt unchanged. After hready=1, arbitration resumes on the first edge.
- Reset asserted while master 3 owns a locked transfer -> next edge hgrant=4'b0001, hmastlock=0, state PARK.
